// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register. It owns the PC, fetches words over a req/ready
// handshake, holds the IF/ID register while decode stalls, and flushes on EX redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] target;
    logic        unused_redirect_lsbs;

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign imem_req             = (state == FETCH) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect) begin
                        pc        <= target;
                        imem_addr <= target;
                    end
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        pc          <= target;
                        // An unanswered request cannot be withdrawn, so wait it out in DRAIN.
                        if (imem_ready) begin
                            imem_addr <= target;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ready && !stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= imem_rdata;
                        if_id_pc    <= pc;
                        if_id_pc4   <= inc4(pc);
                        pc          <= inc4(pc);
                        imem_addr   <= inc4(pc);
                    end else if (imem_ready) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc;
                        state      <= HOLD;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        pc          <= target;
                        imem_addr   <= target;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= skid_instr;
                        if_id_pc    <= skid_pc;
                        if_id_pc4   <= inc4(skid_pc);
                        pc          <= inc4(pc);
                        imem_addr   <= inc4(pc);
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    // The stale response is dropped; the latest target wins.
                    if (imem_ready) begin
                        imem_addr <= redirect ? target : pc;
                        state     <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized latency/stall/redirect traffic,
// checked against a program-order model of which instruction decode should receive next.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wmin = 0, wmax = 0, cur_wait = 0, waited = 0;
    int consumed = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        have_prev = 1'b0;
    logic        prev_req, prev_rdy, prev_stall, prev_redir, prev_valid;
    logic [31:0] prev_addr, prev_instr, prev_pc, prev_pc4;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    // Called at a negedge: drives inputs, checks outputs, advances one clock to the next negedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        logic req_s, rdy_s;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (imem_req && waited >= cur_wait) begin
            imem_ready = 1'b1;
            imem_rdata = mem_data(imem_addr);
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
        end
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (have_prev && prev_req && !prev_rdy) begin
            chk1("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, prev_addr);
        end
        if (have_prev && prev_stall && !prev_redir) begin
            chk1("stall_valid", if_id_valid, prev_valid);
            chk("stall_instr", if_id_instr, prev_instr);
            chk("stall_pc", if_id_pc, prev_pc);
            chk("stall_pc4", if_id_pc4, prev_pc4);
        end
        if (have_prev && prev_redir) chk1("flush_valid", if_id_valid, 1'b0);
        if (!if_id_valid) chk("bubble_nop", if_id_instr, NOP_INSTR);
        if (if_id_valid && !st && !rd) begin
            chk("seq_pc", if_id_pc, exp_pc);
            chk("seq_instr", if_id_instr, mem_data(exp_pc));
            chk("seq_pc4", if_id_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (rd) exp_pc = {rpc[31:2], 2'b00};
        have_prev  = 1'b1;
        prev_req   = imem_req;
        prev_rdy   = imem_ready;
        prev_addr  = imem_addr;
        prev_stall = st;
        prev_redir = rd;
        prev_valid = if_id_valid;
        prev_instr = if_id_instr;
        prev_pc    = if_id_pc;
        prev_pc4   = if_id_pc4;
        req_s = imem_req;
        rdy_s = imem_ready;
        if (req_s) begin
            if (rdy_s) begin
                waited   = 0;
                cur_wait = $urandom_range(wmax, wmin);
            end else begin
                waited++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: pulses rst_n mid-cycle and releases it on the following negedge.
    task automatic do_reset();
        #2;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        #1;
        chk1("rst_valid", if_id_valid, 1'b0);
        chk("rst_instr", if_id_instr, NOP_INSTR);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n     = 1'b1;
        waited    = 0;
        cur_wait  = $urandom_range(wmax, wmin);
        have_prev = 1'b0;
        exp_pc    = RESET_PC;
    endtask

    initial begin : main
        logic [3:0]  vpat;
        logic [31:0] rpc;
        logic        st, rd;
        int          c0;

        @(negedge clk);

        // 1: zero-wait memory, back-to-back fetch
        wmin = 0; wmax = 0;
        do_reset();
        chk1("t1_boot_req", imem_req, 1'b0);
        cycle(1'b0, 1'b0, '0);
        chk1("t1_req_c1", imem_req, 1'b1);
        chk("t1_addr_c1", imem_addr, 32'h0000_1000);
        cycle(1'b0, 1'b0, '0);
        chk1("t1_valid0", if_id_valid, 1'b1);
        chk("t1_pc0", if_id_pc, 32'h0000_1000);
        cycle(1'b0, 1'b0, '0);
        chk("t1_pc1", if_id_pc, 32'h0000_1004);
        cycle(1'b0, 1'b0, '0);
        chk("t1_pc2", if_id_pc, 32'h0000_1008);
        chk1("t1_valid2", if_id_valid, 1'b1);

        // 2: three-cycle memory latency
        wmin = 2; wmax = 2;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr_held", imem_addr, 32'h0000_1000);
            cycle(1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            vpat[3-i] = if_id_valid;
            cycle(1'b0, 1'b0, '0);
        end
        chk("t2_valid_pattern", {28'd0, vpat}, 32'h0000_0009);

        // 3: stall while the response arrives
        wmin = 0; wmax = 0;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk1("t3_hold_req", imem_req, 1'b0);
            chk("t3_hold_pc", if_id_pc, 32'h0000_1000);
            cycle(1'b1, 1'b0, '0);
        end
        cycle(1'b0, 1'b0, '0);
        chk("t3_skid_pc", if_id_pc, 32'h0000_1004);
        chk1("t3_skid_valid", if_id_valid, 1'b1);
        chk("t3_next_addr", imem_addr, 32'h0000_1008);

        // 4: redirect while a request is outstanding
        wmin = 3; wmax = 3;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_2003);
        chk1("t4_drain_req", imem_req, 1'b1);
        chk("t4_drain_addr", imem_addr, 32'h0000_1000);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        chk("t4_new_addr", imem_addr, 32'h0000_2000);
        for (int i = 0; i < 12 && !if_id_valid; i++) cycle(1'b0, 1'b0, '0);
        chk1("t4_valid", if_id_valid, 1'b1);
        chk("t4_pc", if_id_pc, 32'h0000_2000);
        chk("t4_instr", if_id_instr, mem_data(32'h0000_2000));

        // 5: redirect with stall and with ready in the same cycle, then from HOLD
        wmin = 0; wmax = 0;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_3000);
        chk1("t5_flush_valid", if_id_valid, 1'b0);
        chk("t5_flush_instr", if_id_instr, NOP_INSTR);
        chk("t5_target_addr", imem_addr, 32'h0000_3000);
        cycle(1'b0, 1'b0, '0);
        chk("t5_target_pc", if_id_pc, 32'h0000_3000);
        cycle(1'b1, 1'b0, '0);
        chk1("t5_hold_req", imem_req, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_4008);
        chk1("t5_hold_flush", if_id_valid, 1'b0);
        chk("t5_hold_addr", imem_addr, 32'h0000_4008);
        cycle(1'b0, 1'b0, '0);
        chk("t5_hold_target", if_id_pc, 32'h0000_4008);

        // 6: PC wrap, then reset in the middle of DRAIN
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, '0);
        chk("t6_wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_pc4", if_id_pc4, 32'h0000_0000);
        cycle(1'b0, 1'b0, '0);
        chk("t6_zero_pc", if_id_pc, 32'h0000_0000);
        chk("t6_zero_pc4", if_id_pc4, 32'h0000_0004);
        wmin = 3; wmax = 3;
        do_reset();
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_5000);
        chk1("t6_drain_req", imem_req, 1'b1);
        chk("t6_drain_addr", imem_addr, 32'h0000_1000);
        do_reset();
        chk1("t6_boot_req", imem_req, 1'b0);
        cycle(1'b0, 1'b0, '0);
        chk("t6_restart_addr", imem_addr, RESET_PC);

        // Randomized traffic
        wmin = 0; wmax = 3;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(9, 0) < 3);
            rd = ($urandom_range(39, 0) == 0);
            rpc = $urandom_range(1, 0) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
            if ($urandom_range(499, 0) == 0) do_reset();
            else cycle(st, rd, rpc);
        end
        chk1("rand_progress", (consumed - c0) > 150, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
